// File: rtl/z80_bus_target_if.sv
// z80_bus_target_if
//   Bundles the Z80-side strobes/data, the memory backend request/response
//   and the interrupt sources used by z80_bus_target.
//   CPU side    : ADDR, DO, WR, MREQ, IORQ, M1 (to target); DI, WAIT, INT (from target)
//   Backend side: mem_req, mem_we, mem_addr, mem_wdata (from target); mem_rdata, mem_ack (to target)
//   Interrupts  : irq_src (level sources, to target)
//   slave  modport: the target's view; master modport: the CPU/backend view.
interface z80_bus_target_if;
    logic [15:0] ADDR;
    logic [7:0]  DO;
    logic        WR;
    logic        MREQ;
    logic        IORQ;
    logic        M1;
    logic [7:0]  DI;
    logic        WAIT;
    logic        INT;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [3:0]  irq_src;

    modport slave (
        input  ADDR, DO, WR, MREQ, IORQ, M1, mem_rdata, mem_ack, irq_src,
        output DI, WAIT, INT, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ADDR, DO, WR, MREQ, IORQ, M1, mem_rdata, mem_ack, irq_src,
        input  DI, WAIT, INT, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/z80_bus_target.sv
// z80_bus_target
//   Z80 bus target: forwards memory cycles to a request/ack backend with
//   optional extra wait states, and serves a 4-register I/O window
//   (SCRATCH, VECTOR, ENABLE, STATUS) plus interrupt-acknowledge vectoring.
//   Parameters: WAIT_CYCLES - extra wait cycles after backend ack (0..15)
//               IO_BASE     - base of the I/O window on ADDR[7:0]
//   Ports: CLK   - clock, all state on rising edge
//          RESET - asynchronous active-high reset
//          bus   - z80_bus_target_if.slave (CPU strobes/data, backend, irq_src)
module z80_bus_target #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  IO_BASE     = 8'h00
) (
    input  logic               CLK,
    input  logic               RESET,
    z80_bus_target_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    logic [3:0]  counter;
    logic [7:0]  scratch, vector;
    logic [3:0]  enable, status;
    logic [7:0]  io_offset;
    logic [7:0]  io_rdata;
    logic [3:0]  pending;
    logic [3:0]  status_clr;
    logic [1:0]  inta_idx;
    logic        inta_hit;
    logic        start_io;

    // Decode of the current I/O / INTA access and the interrupt priority pick.
    always_comb begin
        start_io  = (state == IDLE) && !bus.MREQ && bus.IORQ;
        io_offset = bus.ADDR[7:0] - IO_BASE;
        pending   = status & enable;

        inta_hit = 1'b0;
        inta_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (pending[i] && !inta_hit) begin
                inta_hit = 1'b1;
                inta_idx = 2'(i);
            end
        end

        case (io_offset)
            8'd0:    io_rdata = scratch;
            8'd1:    io_rdata = vector;
            8'd2:    io_rdata = {4'b0000, enable};
            8'd3:    io_rdata = {4'b0000, status};
            default: io_rdata = 8'hFF;
        endcase

        status_clr = '0;
        if (start_io && bus.M1) begin
            if (inta_hit) status_clr[inta_idx] = 1'b1;
        end else if (start_io && bus.WR && io_offset == 8'd3) begin
            status_clr = bus.DO[3:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.MREQ)      state_next = MEM_REQ;
                else if (bus.IORQ) state_next = DONE;
            end
            MEM_REQ: begin
                if (bus.mem_ack) state_next = (WAIT_CYCLES == 0) ? DONE : MEM_WAIT;
            end
            MEM_WAIT: begin
                // <= rather than == so an out-of-range count can never stall here
                if (counter <= 4'd1) state_next = DONE;
            end
            DONE: begin
                if (!bus.MREQ && !bus.IORQ) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset gates WAIT so the CPU is released the instant RESET rises.
    assign bus.WAIT = !RESET &&
                      (((state == IDLE) && bus.MREQ) || state == MEM_REQ || state == MEM_WAIT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.DI        <= 8'hFF;
            bus.INT       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            scratch       <= '0;
            vector        <= '0;
            enable        <= '0;
            status        <= '0;
            counter       <= '0;
        end else begin
            // Sources OR in after the clear so a same-cycle set wins.
            status  <= (status & ~status_clr) | bus.irq_src;
            bus.INT <= |pending;

            case (state)
                IDLE: begin
                    if (bus.MREQ) begin
                        bus.mem_addr  <= bus.ADDR;
                        bus.mem_wdata <= bus.DO;
                        bus.mem_we    <= bus.WR;
                        bus.mem_req   <= 1'b1;
                    end else if (bus.IORQ) begin
                        if (bus.M1) begin
                            // inta_idx is 0 when nothing is pending, giving VECTOR[7:3],000
                            bus.DI <= {vector[7:3], inta_idx, 1'b0};
                        end else if (bus.WR) begin
                            case (io_offset)
                                8'd0:    scratch <= bus.DO;
                                8'd1:    vector  <= bus.DO;
                                8'd2:    enable  <= bus.DO[3:0];
                                default: ;
                            endcase
                        end else begin
                            bus.DI <= io_rdata;
                        end
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        if (!bus.mem_we) bus.DI <= bus.mem_rdata;
                        counter <= WAIT_INIT;
                    end
                end
                MEM_WAIT: counter <= counter - 4'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/z80_bus_target.md
Z80_BUS_TARGET -- requirements
Module: z80_bus_target

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait cycles after backend ack (0..15).
REQ-002 SHALL have parameter IO_BASE, default 8'h00, meaning base of the 4-port I/O register window (ADDR[7:0]).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ADDR  input  16  CPU address.
REQ-006 SHALL have port DO  input  8  CPU write data.
REQ-007 SHALL have ports WR, MREQ, IORQ, M1  input  1 each  CPU strobes, active-high.
REQ-008 SHALL have port DI  output  8  read data to CPU, registered.
REQ-009 SHALL have port WAIT  output  1  active-high CPU stall.
REQ-010 SHALL have port INT  output  1  active-high interrupt request, registered.
REQ-011 SHALL have ports mem_req/mem_we  output  1 each, mem_addr  output  16, mem_wdata  output  8  backend request.
REQ-012 SHALL have ports mem_rdata  input  8, mem_ack  input  1  backend response.
REQ-013 SHALL have port irq_src  input  4  level interrupt sources.

Function
REQ-014 SHALL implement FSM states IDLE, MEM_REQ, MEM_WAIT, DONE; I/O and INTA accesses go IDLE->DONE in one cycle.
REQ-015 In IDLE, MREQ high SHALL latch ADDR->mem_addr, DO->mem_wdata, WR->mem_we, set mem_req=1, go MEM_REQ.
REQ-016 If MREQ and IORQ are high together, MREQ SHALL take priority.
REQ-017 In MEM_REQ, mem_req SHALL stay 1 until mem_ack; on mem_ack: mem_req=0, DI<=mem_rdata if mem_we=0 (else DI unchanged), counter<=WAIT_CYCLES, go MEM_WAIT (or DONE if WAIT_CYCLES=0).
REQ-018 MEM_WAIT SHALL decrement the counter each cycle and go DONE on the cycle it reads 1.
REQ-019 WAIT SHALL be combinational: 1 when (IDLE and MREQ) or state is MEM_REQ or MEM_WAIT; else 0.
REQ-020 DONE SHALL hold until MREQ=0 and IORQ=0, then return to IDLE; no new access starts in DONE.
REQ-021 I/O (IDLE, IORQ=1, M1=0) with ADDR[7:0]-IO_BASE = 0..3 SHALL address SCRATCH, VECTOR, ENABLE[3:0], STATUS[3:0]; reads load DI (unused bits 0), writes update register; WAIT stays 0.
REQ-022 Unmapped I/O read SHALL set DI=8'hFF; unmapped write SHALL be ignored.
REQ-023 STATUS[i] SHALL set each cycle irq_src[i]=1; write to STATUS SHALL clear bits written 1; set wins over same-cycle clear.
REQ-024 INT SHALL be registered |(STATUS & ENABLE).
REQ-025 INTA (IDLE, IORQ=1, M1=1) SHALL set DI={VECTOR[7:3], n[1:0], 1'b0}, n = lowest index with STATUS&ENABLE set, and clear STATUS[n]; with none pending DI={VECTOR[7:3],3'b000}, nothing cleared.
REQ-026 mem_ack outside MEM_REQ SHALL be ignored.
REQ-027 Address/data SHALL wrap at no boundary; mem_addr is ADDR verbatim.

Reset
REQ-028 RESET high SHALL immediately force state IDLE, DI=8'hFF, WAIT=0 combinationally, INT=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, SCRATCH/VECTOR/ENABLE/STATUS=0, counter=0.
REQ-029 RESET asserted mid-access SHALL abandon it; a later mem_ack SHALL not change DI.

Verification
REQ-030 MREQ=1,WR=0,ADDR=16'h1234; mem_ack after 2 cycles with mem_rdata=8'hA5 -> mem_addr=16'h1234, WAIT high 4 cycles (WAIT_CYCLES=1), DI=8'hA5.
REQ-031 MREQ=1,WR=1,DO=8'h3C -> mem_we=1, mem_wdata=8'h3C, DI unchanged after ack.
REQ-032 I/O write 8'h5A to port 8'h00 then read -> DI=8'h5A, WAIT never 1; read port 8'h07 -> DI=8'hFF.
REQ-033 ENABLE=4'b1100, VECTOR=8'h40, irq_src=4'b1010 one cycle -> INT=1; INTA -> DI=8'h46, STATUS=4'b0010, INT=0.
REQ-034 RESET pulsed during MEM_REQ, then mem_ack with 8'h77 -> mem_req=0, WAIT=0, DI=8'hFF.
REQ-035 irq_src[0]=1 held while STATUS written 8'h01 -> STATUS[0] remains 1.
